// File: rtl/dm_cache_ctrl_pkg.sv
// cache_def: shared types, tag field bounds and word-merge helper for the direct-mapped cache
package cache_def;
    localparam int TAGMSB = 31;
    localparam int TAGLSB = 14;
    typedef struct packed {
        logic                     valid;
        logic                     dirty;
        logic [TAGMSB-TAGLSB:0]   tag;
    } cache_tag_type;
    typedef struct packed {
        logic [9:0] index;
        logic       we;
    } cache_req_type;
    typedef logic [127:0] cache_data_type;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;
    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;
    typedef struct packed {
        logic [31:0]    addr;
        cache_data_type data;
        logic           rw;
        logic           valid;
    } mem_req_type;
    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;
    typedef enum logic [2:0] {INIT, IDLE, COMPARE, ALLOCATE, WRITE_BACK} cache_state_type;
    function automatic cache_data_type merge_word(cache_data_type line, logic [1:0] sel, logic [31:0] w);
        cache_data_type r;
        r = line;
        r[sel*32 +: 32] = w;
        return r;
    endfunction
endpackage

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: write-back write-allocate direct-mapped cache FSM (CACHE_STATS_EN adds hit/miss/wb counters)
module dm_cache_ctrl
    import cache_def::*;
#(
    parameter int INIT_LINES = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  cpu_req_type    cpu_req,
    output cpu_result_type cpu_res,
    input  mem_data_type   mem_data,
    output mem_req_type    mem_req,
    input  cache_tag_type  tag_read,
    output cache_tag_type  tag_write,
    output cache_req_type  tag_req,
    input  cache_data_type data_read,
    output cache_data_type data_write,
    output cache_req_type  data_req
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]    hit_cnt,
    output logic [31:0]    miss_cnt,
    output logic [31:0]    wb_cnt
`endif
);
    cache_state_type state_q, state_d;
    cpu_req_type     req_q;
    logic [31:0]     vic_addr_q;
    cache_data_type  vic_data_q;
    logic [9:0]      cnt_q;
    logic [TAGMSB-TAGLSB:0] tag;
    logic [9:0]      idx;
    logic [1:0]      word;
    logic            hit;
    assign tag  = req_q.addr[TAGMSB:TAGLSB];
    assign idx  = req_q.addr[13:4];
    assign word = req_q.addr[3:2];
    assign hit  = tag_read.valid && tag_read.tag == tag;
    // outputs stay zero for as long as rst is held, not just after the first edge
    always_comb begin
        state_d    = state_q;
        cpu_res    = '0;
        mem_req    = '0;
        tag_write  = '0;
        data_write = '0;
        tag_req    = '{index: idx, we: 1'b0};
        data_req   = '{index: idx, we: 1'b0};
        if (!rst) begin
            unique case (state_q)
                INIT: begin
                    tag_req = '{index: cnt_q, we: 1'b1};
                    state_d = cnt_q == 10'(INIT_LINES - 1) ? IDLE : INIT;
                end
                IDLE: state_d = cpu_req.valid ? COMPARE : IDLE;
                COMPARE: begin
                    if (hit) begin
                        cpu_res = '{data: data_read[word*32 +: 32], ready: 1'b1};
                        if (req_q.rw) begin
                            data_write = merge_word(data_read, word, req_q.data);
                            data_req.we = 1'b1;
                            tag_write = '{valid: 1'b1, dirty: 1'b1, tag: tag};
                            tag_req.we = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        state_d = tag_read.valid && tag_read.dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    mem_req = '{addr: vic_addr_q, data: vic_data_q, rw: 1'b1, valid: 1'b1};
                    state_d = mem_data.ready ? ALLOCATE : WRITE_BACK;
                end
                ALLOCATE: begin
                    mem_req = '{addr: {tag, idx, 4'b0}, data: '0, rw: 1'b0, valid: 1'b1};
                    if (mem_data.ready) begin
                        data_write = mem_data.data;
                        data_req.we = 1'b1;
                        tag_write = '{valid: 1'b1, dirty: 1'b0, tag: tag};
                        tag_req.we = 1'b1;
                        state_d = COMPARE;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            req_q      <= '0;
            vic_addr_q <= '0;
            vic_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) cnt_q <= cnt_q + 10'd1;
            if (state_q == IDLE && cpu_req.valid) req_q <= cpu_req;
            if (state_q == COMPARE && !hit) begin
                vic_addr_q <= {tag_read.tag, idx, 4'b0};
                vic_data_q <= data_read;
            end
        end
    end
`ifdef CACHE_STATS_EN
    logic from_idle_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            from_idle_q <= 1'b0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            wb_cnt      <= '0;
        end else begin
            from_idle_q <= state_q == IDLE;
            hit_cnt  <= hit_cnt + 32'(state_q == COMPARE && hit && from_idle_q && hit_cnt != '1);
            miss_cnt <= miss_cnt + 32'(state_q == COMPARE && !hit && miss_cnt != '1);
            wb_cnt   <= wb_cnt + 32'(state_q == WRITE_BACK && mem_data.ready && wb_cnt != '1);
        end
    end
`endif
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: scoreboard bench with tag/data memory and main-memory models around dm_cache_ctrl
module tb_dm_cache_ctrl;
    import cache_def::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    mem_data_type   mem_data;
    mem_req_type    mem_req;
    cache_tag_type  tag_read, tag_write;
    cache_req_type  tag_req, data_req;
    cache_data_type data_read, data_write;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif
    dm_cache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_res(cpu_res),
        .mem_data(mem_data), .mem_req(mem_req),
        .tag_read(tag_read), .tag_write(tag_write), .tag_req(tag_req),
        .data_read(data_read), .data_write(data_write), .data_req(data_req)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );
    cache_tag_type  tag_mem [1024];
    cache_data_type data_mem[1024];
    always @(posedge clk) begin
        if (tag_req.we) tag_mem[tag_req.index] <= tag_write;
        if (data_req.we) data_mem[data_req.index] <= data_write;
    end
    assign tag_read  = tag_mem[tag_req.index];
    assign data_read = data_mem[data_req.index];
    typedef struct {
        logic [31:0]  addr;
        logic         rw;
        logic [127:0] data;
    } mem_exp_t;
    mem_exp_t     mem_q[$];
    logic [31:0]  cpu_q[$];
    logic [127:0] store[logic [31:0]];
    int pass_n = 0;
    int total_n = 0;
    int mem_lat = 0;
    localparam logic [127:0] LINE10 = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    localparam logic [127:0] LINE10_MOD = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'h12345678, 32'hAAAAAAAA};
    function automatic logic [127:0] line_of(logic [31:0] a);
        if (store.exists(a)) return store[a];
        return {a | 32'hC, a | 32'h8, a | 32'h4, a};
    endfunction
    // main memory: checks each new request against mem_q, answers after mem_lat cycles
    mem_req_type cur;
    logic active = 1'b0;
    logic stable = 1'b1;
    logic drop_chk = 1'b0;
    int   wait_n = 0;
    initial begin
        mem_data = '0;
        forever begin
            @(negedge clk);
            if (mem_data.ready) begin
                mem_data.ready = 1'b0;
                if (drop_chk) begin
                    total_n++;
                    if (mem_req.valid !== 1'b0) $display("FAIL mem_valid_drop valid=%b expected 0", mem_req.valid);
                    else pass_n++;
                    drop_chk = 1'b0;
                end
            end
            if (!mem_req.valid) active = 1'b0;
            else begin
                if (!active) begin
                    active = 1'b1;
                    cur = mem_req;
                    wait_n = mem_lat;
                    stable = 1'b1;
                    total_n++;
                    if (mem_q.size() == 0) $display("FAIL mem_unexpected addr=%h rw=%b", cur.addr, cur.rw);
                    else begin
                        mem_exp_t e;
                        e = mem_q.pop_front();
                        if (cur.addr !== e.addr || cur.rw !== e.rw || (e.rw && cur.data !== e.data))
                            $display("FAIL mem_req addr=%h rw=%b data=%h expected addr=%h rw=%b data=%h",
                                     cur.addr, cur.rw, cur.data, e.addr, e.rw, e.data);
                        else pass_n++;
                    end
                end else if (mem_req !== cur) stable = 1'b0;
                if (wait_n == 0) begin
                    total_n++;
                    if (!stable) $display("FAIL mem_stable addr=%h changed while waiting", cur.addr);
                    else pass_n++;
                    mem_data.data = cur.rw ? '0 : line_of(cur.addr);
                    if (cur.rw) store[cur.addr] = cur.data;
                    mem_data.ready = 1'b1;
                    active = 1'b0;
                    drop_chk = !cur.rw;
                end else wait_n--;
            end
        end
    end
    task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic w,
                          output logic [31:0] rd, output int lat);
        cpu_req = '{addr: a, data: d, rw: w, valid: 1'b1};
        lat = -1;
        rd = 'x;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (cpu_res.ready) begin
                rd = cpu_res.data;
                lat = i;
                break;
            end
        end
        cpu_req.valid = 1'b0;
        @(negedge clk);
    endtask
    logic [31:0] rd, e;
    int lat;
    task automatic test_reset();
        logic ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_n++;
        if (cpu_res !== '0 || mem_req.valid !== 1'b0 || tag_req.we !== 1'b0 || data_req.we !== 1'b0)
            $display("FAIL reset_outputs cpu_res=%h mem_valid=%b tag_we=%b data_we=%b expected all 0",
                     cpu_res, mem_req.valid, tag_req.we, data_req.we);
        else pass_n++;
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            #1;
            if (!(tag_req.we === 1'b1 && tag_req.index === 10'(i) && tag_write === '0 &&
                  cpu_res.ready === 1'b0 && mem_req.valid === 1'b0)) ok = 1'b0;
            @(negedge clk);
        end
        total_n++;
        if (!ok) $display("FAIL init_sweep ok=%b expected 1", ok);
        else pass_n++;
        total_n++;
        if (tag_req.we !== 1'b0) $display("FAIL init_done tag_we=%b expected 0", tag_req.we);
        else pass_n++;
        ok = 1'b1;
        for (int i = 0; i < 1024; i++) if (tag_mem[i].valid !== 1'b0) ok = 1'b0;
        total_n++;
        if (!ok) $display("FAIL init_tags_invalid ok=%b expected 1", ok);
        else pass_n++;
    endtask
    task automatic test_read_miss();
        mem_lat = 0;
        mem_q.push_back('{addr: 32'h10, rw: 1'b0, data: '0});
        cpu_q.push_back(32'hAAAAAAAA);
        cpu_op(32'h10, 32'h0, 1'b0, rd, lat);
        e = cpu_q.pop_front();
        total_n++;
        if (rd !== e || lat != 3) $display("FAIL read_miss data=%h lat=%0d expected %h lat=3", rd, lat, e);
        else pass_n++;
`ifdef CACHE_STATS_EN
        total_n++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0)
            $display("FAIL stats_miss miss=%0d hit=%0d expected 1 0", miss_cnt, hit_cnt);
        else pass_n++;
`endif
    endtask
    task automatic test_write_hit();
        cpu_op(32'h14, 32'h12345678, 1'b1, rd, lat);
        total_n++;
        if (lat != 1) $display("FAIL write_hit lat=%0d expected 1", lat);
        else pass_n++;
        total_n++;
        if (data_mem[1] !== LINE10_MOD || tag_mem[1] !== '{valid: 1'b1, dirty: 1'b1, tag: 18'h0})
            $display("FAIL write_hit_line line=%h tag=%h expected %h dirty valid tag0", data_mem[1], tag_mem[1], LINE10_MOD);
        else pass_n++;
        cpu_q.push_back(32'h12345678);
        cpu_op(32'h14, 32'h0, 1'b0, rd, lat);
        e = cpu_q.pop_front();
        total_n++;
        if (rd !== e || lat != 1) $display("FAIL read_hit data=%h lat=%0d expected %h lat=1", rd, lat, e);
        else pass_n++;
`ifdef CACHE_STATS_EN
        total_n++;
        if (hit_cnt !== 32'd2) $display("FAIL stats_hit hit=%0d expected 2", hit_cnt);
        else pass_n++;
`endif
    endtask
    task automatic test_dirty_miss();
        mem_lat = 5;
        mem_q.push_back('{addr: 32'h10, rw: 1'b1, data: LINE10_MOD});
        mem_q.push_back('{addr: 32'h4010, rw: 1'b0, data: '0});
        cpu_q.push_back(32'h4010);
        cpu_op(32'h4010, 32'h0, 1'b0, rd, lat);
        e = cpu_q.pop_front();
        total_n++;
        if (rd !== e || lat != 14) $display("FAIL dirty_miss data=%h lat=%0d expected %h lat=14", rd, lat, e);
        else pass_n++;
`ifdef CACHE_STATS_EN
        total_n++;
        if (wb_cnt !== 32'd1 || miss_cnt !== 32'd2)
            $display("FAIL stats_wb wb=%0d miss=%0d expected 1 2", wb_cnt, miss_cnt);
        else pass_n++;
`endif
    endtask
    task automatic test_back_to_back();
        mem_lat = 0;
        cpu_op(32'h4018, 32'hCAFEF00D, 1'b1, rd, lat);
        total_n++;
        if (lat != 1) $display("FAIL b2b_write lat=%0d expected 1", lat);
        else pass_n++;
        cpu_q.push_back(32'hCAFEF00D);
        cpu_op(32'h4018, 32'h0, 1'b0, rd, lat);
        e = cpu_q.pop_front();
        total_n++;
        if (rd !== e || lat != 1) $display("FAIL b2b_read data=%h lat=%0d expected %h lat=1", rd, lat, e);
        else pass_n++;
        cpu_q.push_back(32'h401C);
        cpu_op(32'h401F, 32'h0, 1'b0, rd, lat);
        e = cpu_q.pop_front();
        total_n++;
        if (rd !== e || lat != 1) $display("FAIL b2b_word3 data=%h lat=%0d expected %h lat=1", rd, lat, e);
        else pass_n++;
    endtask
    task automatic test_reset_mid();
        logic seen;
        mem_lat = 20;
        mem_q.push_back('{addr: 32'h20, rw: 1'b0, data: '0});
        cpu_req = '{addr: 32'h20, data: 32'h0, rw: 1'b0, valid: 1'b1};
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req.valid;
        end
        total_n++;
        if (!seen) $display("FAIL alloc_start seen=%b expected 1", seen);
        else pass_n++;
        rst = 1'b1;
        cpu_req.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_n++;
        if (mem_req.valid !== 1'b0 || tag_req.we !== 1'b1 || tag_req.index !== 10'd0)
            $display("FAIL reset_mid valid=%b tag_we=%b index=%0d expected 0 1 0", mem_req.valid, tag_req.we, tag_req.index);
        else pass_n++;
        repeat (1024) @(negedge clk);
        mem_lat = 0;
        mem_q.push_back('{addr: 32'h10, rw: 1'b0, data: '0});
        cpu_q.push_back(32'h12345678);
        cpu_op(32'h14, 32'h0, 1'b0, rd, lat);
        e = cpu_q.pop_front();
        total_n++;
        if (rd !== e || lat != 3) $display("FAIL post_reset_miss data=%h lat=%0d expected %h lat=3", rd, lat, e);
        else pass_n++;
`ifdef CACHE_STATS_EN
        total_n++;
        if (miss_cnt !== 32'd1 || wb_cnt !== 32'd0 || hit_cnt !== 32'd0)
            $display("FAIL stats_cleared miss=%0d wb=%0d hit=%0d expected 1 0 0", miss_cnt, wb_cnt, hit_cnt);
        else pass_n++;
`endif
    endtask
    initial begin
        rst = 1'b1;
        cpu_req = '0;
        for (int i = 0; i < 1024; i++) begin
            tag_mem[i] = '{valid: 1'b1, dirty: 1'b1, tag: 18'(i)};
            data_mem[i] = '0;
        end
        store[32'h10] = LINE10;
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_miss();
        test_back_to_back();
        test_reset_mid();
        total_n++;
        if (mem_q.size() != 0 || cpu_q.size() != 0)
            $display("FAIL queues_drained mem=%0d cpu=%0d expected 0 0", mem_q.size(), cpu_q.size());
        else pass_n++;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
